cache_set_select: RTL and testbench

CACHE_SET_SELECT -- requirements
Module: cache_set_select

---
 rtl/cache_set_select.sv | 127 ++++++++++++
 tb/tb_cache_set_select.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cache_set_select.sv
// Set-select front end for a direct-indexed cache: decodes lookup addresses to a set
// one-hot/index, and walks every set for init/invalidate. Option: CACHE_SET_SELECT_REG_OUT_EN.
module cache_set_select #(
    parameter int ADDR_W      = 16,
    parameter int OFFSET_BITS = 4,
    parameter int SET_BITS    = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          addr_in,
    input  logic                       addr_valid,
    output logic                       addr_ready,
    input  logic                       sweep_start,
    input  logic                       sweep_ready,
    output logic [(2**SET_BITS)-1:0]   set_onehot,
    output logic [SET_BITS-1:0]        set_index,
    output logic                       set_valid,
    output logic                       sweep_busy,
    output logic                       sweep_done
);
    localparam int NUM_SETS = 2**SET_BITS;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t              state_reg;
    logic [SET_BITS-1:0] count_reg;
    logic                busy_reg;
    logic                done_reg;

    logic [SET_BITS-1:0] addr_set;
    logic                accept;
    logic                lookup_valid;
    logic [SET_BITS-1:0] lookup_index;
    logic                sel_valid;
    logic [SET_BITS-1:0] sel_index;
    logic                unused_addr;

    assign addr_set    = addr_in[OFFSET_BITS+SET_BITS-1:OFFSET_BITS];
    assign unused_addr = ^addr_in;
    // A sweep request in IDLE pre-empts any lookup presented in the same cycle.
    assign addr_ready  = (state_reg == IDLE) && !sweep_start;
    assign accept      = addr_valid && addr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (sweep_start) begin
                        state_reg <= SWEEP;
                        count_reg <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (sweep_ready) begin
                        if (&count_reg) begin
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            count_reg <= count_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CACHE_SET_SELECT_REG_OUT_EN
    logic                lookup_valid_reg;
    logic [SET_BITS-1:0] lookup_index_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            lookup_valid_reg <= 1'b0;
            lookup_index_reg <= '0;
        end else begin
            lookup_valid_reg <= accept;
            lookup_index_reg <= accept ? addr_set : '0;
        end
    end

    assign lookup_valid = lookup_valid_reg;
    assign lookup_index = lookup_index_reg;
`else
    assign lookup_valid = accept;
    assign lookup_index = addr_set;
`endif

    // Sweep and lookup never overlap: a lookup is only accepted in IDLE.
    always_comb begin
        sel_valid = 1'b0;
        sel_index = '0;
        if (busy_reg) begin
            sel_valid = 1'b1;
            sel_index = count_reg;
        end else if (lookup_valid) begin
            sel_valid = 1'b1;
            sel_index = lookup_index;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SETS; gi++) begin : g_onehot
            assign set_onehot[gi] = sel_valid && (sel_index == SET_BITS'(gi));
        end
    endgenerate

    assign set_index  = sel_index;
    assign set_valid  = sel_valid;
    assign sweep_busy = busy_reg;
    assign sweep_done = done_reg;
endmodule

// File: tb/tb_cache_set_select.sv
// Directed bench for cache_set_select: lookup vector table plus sweep, stall,
// collision and mid-sweep reset sequences. Works with either lookup latency build.
module tb_cache_set_select;
`ifdef CACHE_SET_SELECT_REG_OUT_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr_in;
    logic        addr_valid;
    logic        addr_ready;
    logic        sweep_start;
    logic        sweep_ready;
    logic [63:0] set_onehot;
    logic [5:0]  set_index;
    logic        set_valid;
    logic        sweep_busy;
    logic        sweep_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cache_set_select dut (
        .clk(clk), .rst(rst), .addr_in(addr_in), .addr_valid(addr_valid),
        .addr_ready(addr_ready), .sweep_start(sweep_start), .sweep_ready(sweep_ready),
        .set_onehot(set_onehot), .set_index(set_index), .set_valid(set_valid),
        .sweep_busy(sweep_busy), .sweep_done(sweep_done)
    );

    typedef struct {
        logic [15:0] addr;
        int          idx;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_onehot"}, set_onehot, 64'd0);
        chk({tag, "_index"}, {58'd0, set_index}, 64'd0);
        chk({tag, "_valid"}, {63'd0, set_valid}, 64'd0);
        chk({tag, "_busy"}, {63'd0, sweep_busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, sweep_done}, 64'd0);
        chk({tag, "_ready"}, {63'd0, addr_ready}, 64'd1);
    endtask

    task automatic chk_sel(input string tag, input int idx);
        chk({tag, "_index"}, {58'd0, set_index}, 64'(idx));
        chk({tag, "_onehot"}, set_onehot, 64'd1 << idx);
        chk({tag, "_valid"}, {63'd0, set_valid}, 64'd1);
    endtask

    // Entered #1 after a rising edge; returns #1 after a rising edge.
    task automatic do_lookup(input logic [15:0] a, input int idx, input string tag);
        addr_in = a;
        addr_valid = 1'b1;
        @(negedge clk);
        chk({tag, "_ready"}, {63'd0, addr_ready}, 64'd1);
        if (LAT == 0) chk_sel(tag, idx);
        @(posedge clk); #1;
        addr_valid = 1'b0;
        addr_in = 16'h0000;
        @(negedge clk);
        if (LAT == 1) begin
            chk_sel(tag, idx);
            @(posedge clk); #1;
            @(negedge clk);
        end
        chk({tag, "_single"}, {63'd0, set_valid}, 64'd0);
        @(posedge clk); #1;
        $display("lookup %s addr=%h idx=%0d", tag, a, idx);
    endtask

    task automatic start_sweep();
        sweep_start = 1'b1;
        @(posedge clk); #1;
        sweep_start = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        int exp_idx;
        int stalled;

        vecs[0] = '{16'h0130, 19};
        vecs[1] = '{16'hFFF0, 63};
        vecs[2] = '{16'h000F, 0};
        vecs[3] = '{16'h1234, 35};
        vecs[4] = '{16'hABCD, 60};
        vecs[5] = '{16'h0400, 0};
        vecs[6] = '{16'h03F5, 63};
        vecs[7] = '{16'h0015, 1};

        rst = 1'b1; addr_in = '0; addr_valid = 1'b0;
        sweep_start = 1'b0; sweep_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle("reset");
        @(posedge clk); #1;
        $display("reset released");

        for (int i = 0; i < 8; i++)
            do_lookup(vecs[i].addr, vecs[i].idx, $sformatf("lookup%0d", i));

        // sweep_start and addr_valid together: sweep wins
        addr_in = 16'h0130; addr_valid = 1'b1; sweep_start = 1'b1;
        @(negedge clk);
        chk("collide_ready", {63'd0, addr_ready}, 64'd0);
        chk("collide_valid", {63'd0, set_valid}, 64'd0);
        @(posedge clk); #1;
        addr_valid = 1'b0; sweep_start = 1'b0;
        $display("collision: sweep started");

        // Full sweep with ready held high; also covers the collision-started sweep
        exp_idx = 0;
        for (int cyc = 0; cyc < 200 && exp_idx < 64; cyc++) begin
            @(negedge clk);
            chk_sel($sformatf("sweep%0d", exp_idx), exp_idx);
            chk("sweep_busy", {63'd0, sweep_busy}, 64'd1);
            @(posedge clk); #1;
            exp_idx++;
        end
        chk("sweep_count", 64'(exp_idx), 64'd64);
        sweep_start = 1'b1;  // must be ignored in DONE
        @(negedge clk);
        chk("done_pulse", {63'd0, sweep_done}, 64'd1);
        chk("done_valid", {63'd0, set_valid}, 64'd0);
        chk("done_busy", {63'd0, sweep_busy}, 64'd0);
        @(posedge clk); #1;
        sweep_start = 1'b0;
        @(negedge clk);
        chk_idle("after_done");
        @(posedge clk); #1;
        $display("sweep complete");

        // Stall at index 10 with a blocked lookup; sweep_start mid-sweep ignored
        start_sweep();
        exp_idx = 0; stalled = 0;
        for (int cyc = 0; cyc < 200 && exp_idx < 64; cyc++) begin
            sweep_ready = !(exp_idx == 10 && stalled < 5);
            addr_valid  = (exp_idx == 10);
            addr_in     = 16'h0130;
            sweep_start = (exp_idx == 30);
            @(negedge clk);
            chk_sel($sformatf("stall%0d", exp_idx), exp_idx);
            if (exp_idx == 10)
                chk("stall_ready", {63'd0, addr_ready}, 64'd0);
            if (!sweep_ready) stalled++;
            @(posedge clk); #1;
            if (sweep_ready) exp_idx++;
        end
        addr_valid = 1'b0; sweep_ready = 1'b1; sweep_start = 1'b0;
        chk("stall_count", 64'(exp_idx), 64'd64);
        chk("stall_cycles", 64'(stalled), 64'd5);
        @(negedge clk);
        chk("stall_done", {63'd0, sweep_done}, 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk_idle("stall_after");
        @(posedge clk); #1;
        $display("stalled sweep complete");

        // Reset at index 20
        start_sweep();
        exp_idx = 0;
        for (int cyc = 0; cyc < 100 && exp_idx < 20; cyc++) begin
            @(posedge clk); #1;
            exp_idx++;
        end
        @(negedge clk);
        chk_sel("pre_rst", 20);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_idle("mid_rst");
        @(posedge clk); #1;
        @(negedge clk);
        chk_idle("mid_rst2");
        $display("mid-sweep reset checked");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
